// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the table-driven FSM sequencer.
// Holds the state codes, the controller state enum and the table entry layout.
package fsm_seq_pkg;

   localparam int unsigned NUM_STATES  = 5;
   localparam int          NUM_ENTRIES = int'(NUM_STATES * NUM_STATES);

   localparam logic [2:0] ZERO  = 3'd0;
   localparam logic [2:0] ONE   = 3'd1;
   localparam logic [2:0] TWO   = 3'd2;
   localparam logic [2:0] THREE = 3'd3;
   localparam logic [2:0] FOUR  = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CHECK,
      DONE
   } seq_state_e;

   typedef struct packed {
      logic [2:0] ns;
      logic [3:0] out;
   } tbl_entry_t;

   function automatic logic idx_legal(input logic [2:0] idx);
      return idx < 3'(NUM_STATES);
   endfunction

   // Row-major flat index; only meaningful when both indices are legal.
   function automatic logic [4:0] entry_idx(input logic [2:0] row, input logic [2:0] col);
      return 5'(row) * 5'(NUM_STATES) + 5'(col);
   endfunction

endpackage

// File: rtl/fsm_trans_table.sv
// 5x5 transition table: synchronous write, combinational read.
// Illegal read indices return ns = rd_state, out = 0 so the caller's state holds.
module fsm_trans_table
   import fsm_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [2:0] wr_state,
   input  logic [2:0] wr_in,
   input  tbl_entry_t wr_data,
   output logic       wr_legal,
   input  logic [2:0] rd_state,
   input  logic [2:0] rd_in,
   output tbl_entry_t rd_data,
   output logic       rd_legal
);

   tbl_entry_t mem_q [NUM_ENTRIES];

   assign wr_legal = idx_legal(wr_state) && idx_legal(wr_in);
   assign rd_legal = idx_legal(rd_state) && idx_legal(rd_in);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we && wr_legal) begin
         mem_q[entry_idx(wr_state, wr_in)] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_legal) begin
         rd_data = mem_q[entry_idx(rd_state, rd_in)];
      end else begin
         rd_data.ns = rd_state;
      end
   end

endmodule

// File: rtl/fsm_table_sequencer.sv
// Configures and steps a table-driven Mealy FSM one symbol at a time,
// checking its output against the programmed table and counting mismatches.
module fsm_table_sequencer
   import fsm_seq_pkg::*;
#(
   parameter int unsigned STEP_W = 16,
   parameter int unsigned ERR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_state,
   input  logic [2:0]        cfg_in,
   input  logic [2:0]        cfg_ns,
   input  logic [3:0]        cfg_out,
   output logic              cfg_err,
   input  logic              start,
   input  logic              abort,
   input  logic              stim_valid,
   input  logic [2:0]        stim_in,
   input  logic              stim_last,
   output logic              stim_ready,
   output logic              fsm_reset,
   output logic [2:0]        fsm_in,
   output logic [2:0]        fsm_cs,
   output logic [2:0]        fsm_ns,
   output logic [3:0]        fsm_exp_out,
   input  logic [3:0]        fsm_out,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] step_cnt,
   output logic [ERR_W-1:0]  err_cnt
);

   seq_state_e state_q, state_d;

   logic              cfg_err_q;
   logic              fsm_reset_q;
   logic [2:0]        fsm_in_q, fsm_cs_q, fsm_ns_q, cur_state_q;
   logic [3:0]        fsm_exp_q;
   logic              last_q, illegal_q;
   logic [STEP_W-1:0] step_q;
   logic [ERR_W-1:0]  err_q;

   tbl_entry_t cfg_entry, rd_entry;
   logic       wr_legal, rd_legal;
   logic       mismatch;

   assign cfg_entry.ns  = cfg_ns;
   assign cfg_entry.out = cfg_out;

   fsm_trans_table u_table (
      .clk      (clk),
      .reset    (reset),
      .we       (cfg_we && (state_q == IDLE)),
      .wr_state (cfg_state),
      .wr_in    (cfg_in),
      .wr_data  (cfg_entry),
      .wr_legal (wr_legal),
      .rd_state (cur_state_q),
      .rd_in    (stim_in),
      .rd_data  (rd_entry),
      .rd_legal (rd_legal)
   );

   // Illegal symbols always count as a mismatch, whatever the FSM reports.
   assign mismatch = (fsm_out != fsm_exp_q) || illegal_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (stim_valid) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               state_d = last_q ? DONE : RUN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      stim_ready = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         RUN: begin
            busy       = 1'b1;
            stim_ready = 1'b1;
         end
         CHECK:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_err_q   <= 1'b0;
         fsm_reset_q <= 1'b1;
         fsm_in_q    <= '0;
         fsm_cs_q    <= '0;
         fsm_ns_q    <= '0;
         fsm_exp_q   <= '0;
         cur_state_q <= ZERO;
         last_q      <= 1'b0;
         illegal_q   <= 1'b0;
         step_q      <= '0;
         err_q       <= '0;
      end else begin
         fsm_reset_q <= 1'b0;
         if (cfg_we && ((state_q != IDLE) || !wr_legal)) begin
            cfg_err_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  step_q      <= '0;
                  err_q       <= '0;
                  cur_state_q <= ZERO;
                  fsm_reset_q <= 1'b1;
               end
            end
            RUN: begin
               if (!abort && stim_valid) begin
                  fsm_in_q  <= stim_in;
                  fsm_cs_q  <= cur_state_q;
                  fsm_ns_q  <= rd_entry.ns;
                  fsm_exp_q <= rd_entry.out;
                  last_q    <= stim_last;
                  illegal_q <= !rd_legal;
               end
            end
            CHECK: begin
               if (!abort) begin
                  cur_state_q <= fsm_ns_q;
                  step_q      <= step_q + STEP_W'(1);
                  if (mismatch && (err_q != {ERR_W{1'b1}})) begin
                     err_q <= err_q + ERR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign cfg_err     = cfg_err_q;
   assign fsm_reset   = fsm_reset_q;
   assign fsm_in      = fsm_in_q;
   assign fsm_cs      = fsm_cs_q;
   assign fsm_ns      = fsm_ns_q;
   assign fsm_exp_out = fsm_exp_q;
   assign step_cnt    = step_q;
   assign err_cnt     = err_q;

endmodule

// File: tb/tb_fsm_table_sequencer.sv
// Bench for fsm_table_sequencer: a protocol-level model checked every cycle,
// plus directed runs with hand-computed expectations.
module tb_fsm_table_sequencer;

   logic        clk, reset;
   logic        cfg_we;
   logic [2:0]  cfg_state, cfg_in, cfg_ns;
   logic [3:0]  cfg_out;
   logic        cfg_err;
   logic        start, abort;
   logic        stim_valid, stim_last, stim_ready;
   logic [2:0]  stim_in;
   logic        fsm_reset;
   logic [2:0]  fsm_in, fsm_cs, fsm_ns;
   logic [3:0]  fsm_exp_out, fsm_out;
   logic        busy, done;
   logic [15:0] step_cnt;
   logic [7:0]  err_cnt;

   logic        bad_fsm;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   logic [2:0] cs_log[$];

   fsm_table_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_state   (cfg_state),
      .cfg_in      (cfg_in),
      .cfg_ns      (cfg_ns),
      .cfg_out     (cfg_out),
      .cfg_err     (cfg_err),
      .start       (start),
      .abort       (abort),
      .stim_valid  (stim_valid),
      .stim_in     (stim_in),
      .stim_last   (stim_last),
      .stim_ready  (stim_ready),
      .fsm_reset   (fsm_reset),
      .fsm_in      (fsm_in),
      .fsm_cs      (fsm_cs),
      .fsm_ns      (fsm_ns),
      .fsm_exp_out (fsm_exp_out),
      .fsm_out     (fsm_out),
      .busy        (busy),
      .done        (done),
      .step_cnt    (step_cnt),
      .err_cnt     (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in FSM: a modulo-5 counter whose output is its current state.
   assign fsm_out = bad_fsm ? 4'hF : {1'b0, fsm_cs};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic       m_init = 1'b0;
   logic       m_run, m_chk, m_last, m_done_due, m_freset, m_ill, m_cfg_err;
   logic [2:0] m_in, m_cs, m_ns, m_cur;
   logic [3:0] m_exp;
   int         m_steps, m_errs, idx;
   logic       idle, nd;
   logic [2:0] m_tbl_ns [25];
   logic [3:0] m_tbl_out[25];

   always @(negedge clk) begin
      if (m_init) begin
         check("busy",        32'(busy),        32'(m_run));
         check("stim_ready",  32'(stim_ready),  32'(m_run && !m_chk));
         check("done",        32'(done),        32'(m_done_due));
         check("fsm_reset",   32'(fsm_reset),   32'(m_freset));
         check("fsm_in",      32'(fsm_in),      32'(m_in));
         check("fsm_cs",      32'(fsm_cs),      32'(m_cs));
         check("fsm_ns",      32'(fsm_ns),      32'(m_ns));
         check("fsm_exp_out", 32'(fsm_exp_out), 32'(m_exp));
         check("step_cnt",    32'(step_cnt),    m_steps);
         check("err_cnt",     32'(err_cnt),     m_errs);
         check("cfg_err",     32'(cfg_err),     32'(m_cfg_err));
         if (done) done_cnt++;
      end
      if (reset) begin
         m_init = 1'b1;
         m_run = 0; m_chk = 0; m_last = 0; m_done_due = 0; m_freset = 1; m_ill = 0;
         m_cfg_err = 0; m_in = 0; m_cs = 0; m_ns = 0; m_cur = 0; m_exp = 0;
         m_steps = 0; m_errs = 0;
         for (int i = 0; i < 25; i++) begin
            m_tbl_ns[i] = 0;
            m_tbl_out[i] = 0;
         end
      end else if (m_init) begin
         idle = !m_run && !m_done_due;
         nd = 1'b0;
         m_freset = 1'b0;
         if (cfg_we) begin
            if (idle && cfg_state < 5 && cfg_in < 5) begin
               idx = int'(cfg_state) * 5 + int'(cfg_in);
               m_tbl_ns[idx] = cfg_ns;
               m_tbl_out[idx] = cfg_out;
            end else begin
               m_cfg_err = 1'b1;
            end
         end
         if (idle) begin
            if (start) begin
               m_steps = 0; m_errs = 0; m_cur = 0; m_freset = 1; m_run = 1;
            end
         end else if (m_run && abort) begin
            m_run = 0;
            m_chk = 0;
         end else if (m_run && !m_chk) begin
            if (stim_valid) begin
               m_in = stim_in;
               m_cs = m_cur;
               m_last = stim_last;
               m_ill = (stim_in > 4);
               if (m_ill) begin
                  m_ns = m_cur;
                  m_exp = 0;
               end else begin
                  idx = int'(m_cur) * 5 + int'(stim_in);
                  m_ns = m_tbl_ns[idx];
                  m_exp = m_tbl_out[idx];
               end
               m_chk = 1;
            end
         end else if (m_chk) begin
            if (m_ill || (fsm_out != m_exp)) begin
               if (m_errs != 255) m_errs++;
            end
            m_cur = m_ns;
            m_steps = (m_steps + 1) % 65536;
            m_chk = 0;
            if (m_last) begin
               m_run = 0;
               nd = 1'b1;
            end
         end
         m_done_due = nd;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic cfg_write(input logic [2:0] s, input logic [2:0] i,
                            input logic [2:0] ns, input logic [3:0] o);
      cfg_we = 1'b1; cfg_state = s; cfg_in = i; cfg_ns = ns; cfg_out = o;
      tick(1);
      cfg_we = 1'b0;
   endtask

   task automatic program_mod5();
      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < 5; i++) begin
            cfg_write(3'(s), 3'(i), 3'((s + 1) % 5), 4'(s));
         end
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Returns one cycle after acceptance, i.e. while the symbol is being checked.
   task automatic send(input logic [2:0] sym, input logic lst);
      int n = 0;
      stim_valid = 1'b1; stim_in = sym; stim_last = lst;
      while (!stim_ready && n < 20) begin
         tick(1);
         n++;
      end
      if (!stim_ready) begin
         check("send_timeout", 32'(stim_ready), 32'd1);
         stim_valid = 1'b0; stim_last = 1'b0;
         return;
      end
      tick(1);
      stim_valid = 1'b0; stim_last = 1'b0;
      cs_log.push_back(fsm_cs);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 20) begin
         tick(1);
         n++;
      end
      check("idle_timeout", 32'(busy || done), 32'd0);
   endtask

   initial begin
      logic [2:0] exp_cs[7];
      int d0;
      exp_cs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
      reset = 1'b1; cfg_we = 0; cfg_state = 0; cfg_in = 0; cfg_ns = 0; cfg_out = 0;
      start = 0; abort = 0; stim_valid = 0; stim_in = 0; stim_last = 0; bad_fsm = 0;
      tick(2);
      reset = 1'b0;
      check("rst_fsm_reset", 32'(fsm_reset), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cfg_err", 32'(cfg_err), 32'd0);

      // Modulo-5 counter, matching FSM
      program_mod5();
      d0 = done_cnt;
      cs_log.delete();
      do_start();
      for (int k = 0; k < 7; k++) send(3'((k * 3) % 5), k == 6);
      wait_idle();
      for (int k = 0; k < 7; k++) check("mod5_cs_seq", 32'(cs_log[k]), 32'(exp_cs[k]));
      check("mod5_step", 32'(step_cnt), 32'd7);
      check("mod5_err", 32'(err_cnt), 32'd0);
      check("mod5_done_pulses", done_cnt - d0, 32'd1);

      // Broken FSM: every step mismatches, counter saturates
      bad_fsm = 1'b1;
      do_start();
      for (int k = 0; k < 7; k++) send(3'(k % 5), k == 6);
      wait_idle();
      check("bad_err7", 32'(err_cnt), 32'd7);
      do_start();
      for (int k = 0; k < 300; k++) send(3'(k % 5), k == 299);
      wait_idle();
      check("sat_err", 32'(err_cnt), 32'd255);
      check("sat_step", 32'(step_cnt), 32'd300);
      bad_fsm = 1'b0;

      // Illegal configuration writes
      do_reset();
      cfg_write(3'd5, 3'd0, 3'd3, 4'd9);
      check("cfg_err_row", 32'(cfg_err), 32'd1);
      do_reset();
      cfg_write(3'd0, 3'd6, 3'd3, 4'd9);
      check("cfg_err_col", 32'(cfg_err), 32'd1);
      cfg_write(3'd0, 3'd0, 3'd1, 4'd0);
      do_start();
      send(3'd0, 1'b0);
      send(3'd1, 1'b1);
      check("no_alias_ns", 32'(fsm_ns), 32'd0);
      check("no_alias_out", 32'(fsm_exp_out), 32'd0);
      wait_idle();
      do_reset();
      program_mod5();
      do_start();
      cfg_write(3'd0, 3'd0, 3'd3, 4'd9);
      check("cfg_err_run", 32'(cfg_err), 32'd1);
      send(3'd0, 1'b1);
      check("run_write_ignored", 32'(fsm_ns), 32'd1);
      wait_idle();

      // Illegal stimulus symbol mid-run
      cs_log.delete();
      do_start();
      send(3'd0, 1'b0);
      send(3'd7, 1'b0);
      send(3'd0, 1'b1);
      wait_idle();
      check("ill_cs1", 32'(cs_log[1]), 32'd1);
      check("ill_cs2", 32'(cs_log[2]), 32'd1);
      check("ill_err", 32'(err_cnt), 32'd1);
      check("ill_step", 32'(step_cnt), 32'd3);

      // Abort during the third check
      bad_fsm = 1'b1;
      d0 = done_cnt;
      do_start();
      send(3'd0, 1'b0);
      send(3'd0, 1'b0);
      send(3'd0, 1'b0);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_step", 32'(step_cnt), 32'd2);
      check("abort_err", 32'(err_cnt), 32'd2);
      tick(3);
      check("abort_no_done", done_cnt - d0, 32'd0);
      bad_fsm = 1'b0;
      do_start();
      check("restart_fsm_reset", 32'(fsm_reset), 32'd1);
      check("restart_step", 32'(step_cnt), 32'd0);
      check("restart_err", 32'(err_cnt), 32'd0);
      tick(1);
      check("restart_fsm_reset_drop", 32'(fsm_reset), 32'd0);
      send(3'd2, 1'b1);
      wait_idle();

      // Stall, then reset mid-run
      do_start();
      send(3'd0, 1'b0);
      tick(6);
      check("stall_step", 32'(step_cnt), 32'd1);
      check("stall_cs", 32'(fsm_cs), 32'd0);
      check("stall_ready", 32'(stim_ready), 32'd1);
      send(3'd1, 1'b0);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_fsm_reset", 32'(fsm_reset), 32'd1);
      check("midrst_cs", 32'(fsm_cs), 32'd0);
      check("midrst_step", 32'(step_cnt), 32'd0);
      do_start();
      send(3'd3, 1'b1);
      check("midrst_tbl_ns", 32'(fsm_ns), 32'd0);
      check("midrst_tbl_out", 32'(fsm_exp_out), 32'd0);
      wait_idle();
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected < 200000", $time);
      $fatal(1);
   end

endmodule

// File: doc/fsm_table_sequencer.md
Name: fsm_table_sequencer

Overview:
- Controller that configures and sequences the 5-state table-driven Mealy FSM (`fsm`).
- Holds a programmable 5x5 transition table. Each entry is a next state (3 b) plus an expected output (4 b).
- During a run it accepts a stream of input symbols and drives fsm.in / fsm.cs / fsm.ns / fsm.exp_out one step at a time. It also drives the FSM's reset.
- Compares fsm.out against the table, counts steps and mismatches, and reports completion to the test controller.

Parameters:
- NUM_STATES, 5, number of FSM states / input symbols (legal codes 0..4).
- STEP_W, 16, width of step counter.
- ERR_W, 8, width of saturating mismatch counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe; honoured only in IDLE.
- cfg_state  in  3  table row (current state).
- cfg_in  in  3  table column (input symbol).
- cfg_ns  in  3  next-state value to store.
- cfg_out  in  4  expected output value to store.
- cfg_err  out  1  sticky: a write had an illegal index or was issued outside IDLE.
- start  in  1  begin run, honoured only in IDLE.
- abort  in  1  terminate run.
- stim_valid  in  1  input symbol available.
- stim_in  in  3  input symbol.
- stim_last  in  1  final symbol of the run.
- stim_ready  out  1  sequencer accepts a symbol.
- fsm_reset  out  1  reset to the FSM.
- fsm_in  out  3  drives fsm.in.
- fsm_cs  out  3  drives fsm.cs.
- fsm_ns  out  3  drives fsm.ns.
- fsm_exp_out  out  4  drives fsm.exp_out.
- fsm_out  in  4  fsm.out.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- step_cnt  out  STEP_W  steps completed this run.
- err_cnt  out  ERR_W  mismatches this run, saturating.

Behaviour:
- Reset values:
  - All table entries: ns=0, out=0.
  - FSM state = IDLE; cur_state = 0.
  - All fsm_* data outputs 0; fsm_reset = 1.
  - busy, done, stim_ready, cfg_err = 0; step_cnt = 0; err_cnt = 0.
- Clock and reset: one clock domain. Reset is synchronous and active-high, with ports named clk and reset.
- States:
  - IDLE:
    - Table writes are allowed. A write takes effect on the next edge when cfg_state <= 4 and cfg_in <= 4.
    - If either index is > 4, the write is dropped and cfg_err is set.
    - On start: clear step_cnt and err_cnt, set cur_state = 0, assert fsm_reset for one cycle, go to RUN.
  - RUN:
    - busy = 1, stim_ready = 1.
    - On stim_valid & stim_ready, register fsm_in = stim_in, fsm_cs = cur_state, fsm_ns = table[cur_state][stim_in].ns, fsm_exp_out = table[cur_state][stim_in].out.
    - Latch stim_last, then go to CHECK.
  - CHECK:
    - stim_ready = 0.
    - Compare fsm_out against fsm_exp_out in this cycle; the FSM output is combinational.
    - A mismatch increments err_cnt, which saturates at all-ones.
    - An illegal stim_in (> 4) counts as a mismatch and leaves cur_state unchanged; its lookup returns ns = cur_state, out = 0.
    - Otherwise cur_state <= fsm_ns.
    - step_cnt increments, wrapping at 2^STEP_W.
    - Next state is DONE if stim_last was latched, else RUN.
  - DONE: done = 1 for one cycle, busy = 0, then IDLE. step_cnt and err_cnt hold until the next start.
- Throughput and latency: at most one symbol per 2 cycles. Result is visible on step_cnt/err_cnt on the edge after CHECK.
- abort: in RUN or CHECK, go to IDLE next edge without asserting done. An in-flight CHECK does not update counters. Abort has priority over stim handshake and CHECK update.
- start ignored outside IDLE. cfg_we outside IDLE: ignored, cfg_err set.
- cfg_err clears only on reset.
- Reset mid-run: everything returns to reset values, including the table.
- fsm_* data outputs hold their last value in IDLE and DONE.

Decomposition:
- Package fsm_seq_pkg holds:
  - state codes ZERO..FOUR and NUM_STATES;
  - controller state enum IDLE/RUN/CHECK/DONE;
  - table entry struct {ns[2:0], out[3:0]}.
- One sub-module, fsm_trans_table:
  - 25-entry register array with synchronous write and combinational read;
  - index-legality check on both write and read.

Test Plan:
- Program a modulo-5 counter table (ns = (cs+1)%5 for all inputs; out = cs), run 7 symbols with a matching FSM -> fsm_cs sequence 0,1,2,3,4,0,1; step_cnt = 7; err_cnt = 0; done pulses once.
- Same table, FSM out forced to 4'hF -> err_cnt = 7; after 300 steps err_cnt saturates at 255 while step_cnt = 300.
- Write with cfg_state = 5, then cfg_in = 6 -> entries unchanged; cfg_err = 1. Write during RUN -> ignored; cfg_err = 1.
- stim_in = 7 mid-run -> err_cnt += 1, cur_state unchanged, run continues.
- Assert abort in CHECK on step 3 -> IDLE next cycle; step_cnt = 2; no done pulse. A subsequent start -> fsm_reset pulses 1 cycle; counters cleared.
- Hold stim_valid low 5 cycles in RUN -> outputs stable, no count change. Assert reset mid-run -> all outputs and table return to reset values.
